// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC register, instruction fetch and IF/ID latch with stall, redirect and self-loop halt
// ports: clk/rst (sync, active-high); freeze stalls; branch_taken/branch_addr redirect;
//        imem_addr/imem_data fetch from instruction memory; ifid_instr/ifid_pc/ifid_valid feed decode;
//        halted flags HALT; fetch_count counts delivered instructions
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [5:0]  JMP_OPCODE = 6'b101010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc, r_instr, w_instr, r_ifid_pc, w_ifid_pc, r_count, w_count, w_pc_inc;
  logic        r_valid, w_valid, w_bubble, w_redirect, w_fetch, w_halt;
  assign w_pc_inc    = r_pc + 32'd4;
  assign w_bubble    = r_state != RUN || branch_taken;
  assign w_redirect  = branch_taken && r_state != BOOT;
  assign w_fetch     = r_state == RUN && !branch_taken && !freeze;
  // a jump with offset -1 targets itself, so fetching further is pointless
  assign w_halt      = w_fetch && imem_data[31:26] == JMP_OPCODE && imem_data[15:0] == 16'hFFFF;
  assign imem_addr   = {r_pc[31:2], 2'b00};
  assign ifid_instr  = r_instr;
  assign ifid_pc     = r_ifid_pc;
  assign ifid_valid  = r_valid;
  assign halted      = r_state == HALT;
  assign fetch_count = r_count;
  always_comb begin
    w_instr   = w_bubble ? 32'd0 : w_fetch ? imem_data : r_instr;
    w_ifid_pc = w_bubble ? 32'd0 : w_fetch ? w_pc_inc : r_ifid_pc;
    w_valid   = w_bubble ? 1'b0 : w_fetch ? 1'b1 : r_valid;
    w_count   = w_fetch ? r_count + 32'd1 : r_count;
    w_pc      = w_redirect ? branch_addr & ~32'd3 : (w_fetch && !w_halt) ? w_pc_inc : r_pc;
    w_state   = r_state == BOOT ? RUN : w_halt ? HALT : w_redirect ? RUN : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_ifid_pc <= 32'd0;
      r_valid   <= 1'b0;
      r_count   <= 32'd0;
    end else begin
      r_state   <= w_state;
      r_pc      <= w_pc;
      r_instr   <= w_instr;
      r_ifid_pc <= w_ifid_pc;
      r_valid   <= w_valid;
      r_count   <= w_count;
    end
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; the PC value loaded on reset.
REQ-002 SHALL have parameter JMP_OPCODE, default 6'b101010; the opcode used for self-loop halt detection.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port freeze, input, 1 bit; a hazard stall request from decode.
REQ-006 SHALL have port branch_taken, input, 1 bit; a redirect request from a later stage.
REQ-007 SHALL have port branch_addr, input, 32 bits; the redirect target byte address.
REQ-008 SHALL have port imem_addr, output, 32 bits; the byte address driven to instruction memory, which indexes by addr[31:2].
REQ-009 SHALL have port imem_data, input, 32 bits; the combinational instruction word returned for imem_addr.
REQ-010 SHALL have port ifid_instr, output, 32 bits; the registered instruction handed to decode.
REQ-011 SHALL have port ifid_pc, output, 32 bits; the registered PC+4 of ifid_instr.
REQ-012 SHALL have port ifid_valid, output, 1 bit; high when ifid_instr is a real fetched instruction.
REQ-013 SHALL have port halted, output, 1 bit; high while in state HALT.
REQ-014 SHALL have port fetch_count, output, 32 bits; the number of instructions delivered with ifid_valid=1 since reset.

Function
REQ-015 SHALL hold a 32-bit PC register and drive imem_addr = {PC[31:2], 2'b00} combinationally.
REQ-016 SHALL implement three states: BOOT, RUN and HALT.
REQ-017 SHALL, in BOOT, load a bubble into IF/ID (ifid_instr=0, ifid_pc=0, ifid_valid=0), hold the PC, and go to RUN after exactly one cycle.
REQ-018 SHALL, in RUN, apply the per-cycle priority branch_taken > freeze > normal fetch.
REQ-019 SHALL, on branch_taken, load PC <= {branch_addr[31:2], 2'b00} and load a bubble into IF/ID (ifid_valid=0); the instruction on imem_data that cycle is discarded.
REQ-020 SHALL, on freeze without branch_taken, hold PC, ifid_instr, ifid_pc and ifid_valid unchanged, and leave fetch_count unchanged.
REQ-021 SHALL, on normal fetch, load PC <= PC+4, ifid_instr <= imem_data, ifid_pc <= PC+4, ifid_valid <= 1, and fetch_count <= fetch_count+1.
REQ-022 SHALL compute PC+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-023 SHALL wrap fetch_count modulo 2^32.
REQ-024 SHALL detect a halt when, during a normal fetch, imem_data[31:26]==JMP_OPCODE and imem_data[15:0]==16'hFFFF (jump -1).
REQ-025 SHALL, on halt detection, deliver the jump to IF/ID as a normal fetch, hold PC at the jump's address instead of incrementing it, and go to HALT.
REQ-026 SHALL, in HALT, hold PC, load a bubble into IF/ID every cycle, leave fetch_count unchanged, ignore freeze, and drive halted=1.
REQ-027 SHALL, in HALT with branch_taken=1, redirect as in REQ-019 and return to RUN on the next cycle.
REQ-028 SHALL, when branch_taken and halt detection occur in the same cycle, let branch_taken win with no transition to HALT.
REQ-029 SHALL not detect a halt on a cycle in which freeze=1.

Reset
REQ-030 SHALL, when rst=1 at a rising edge, set PC=RESET_PC, state=BOOT, ifid_instr=0, ifid_pc=0, ifid_valid=0, halted=0 and fetch_count=0.
REQ-031 SHALL give rst priority over branch_taken, freeze and halt detection in every state, including mid-stall and mid-halt.
REQ-032 SHALL drive imem_addr=RESET_PC during the BOOT cycle after reset.

Verification
REQ-033 SHALL cover reset-then-run: rst for 2 cycles, then free run with ROM words 0..4 -> one bubble cycle, then ifid_pc = 4, 8, 12, 16, 20 on consecutive cycles with matching words, and fetch_count=5.
REQ-034 SHALL cover freeze: assert freeze for 3 cycles at PC=8 -> IF/ID, PC=8 and fetch_count all frozen; ifid_pc=12 is delivered on the first cycle after release.
REQ-035 SHALL cover a branch: branch_taken=1 with branch_addr=32'h0000_0043 at PC=16 -> next cycle ifid_valid=0 and imem_addr=32'h40; the following cycle ifid_pc=32'h44.
REQ-036 SHALL cover branch and freeze together: branch_taken and freeze both 1 -> redirect occurs and a bubble is loaded; the freeze is ignored.
REQ-037 SHALL cover halt: word 32'hA800_FFFF at address 0x100 -> it is delivered with ifid_pc=0x104, then halted=1, imem_addr stays 0x100, ifid_valid=0 and fetch_count is constant for 10 cycles; a later branch_taken to 0 resumes fetch and clears halted.
REQ-038 SHALL cover reset mid-operation and PC wrap: rst asserted during a freeze -> all outputs return to reset values next cycle; PC preset to 32'hFFFF_FFFC via branch -> after one fetch ifid_pc=0 and imem_addr=0.
